// File: rtl/arb_mux_nto1.sv
// N-to-1 arbitrated word mux: fixed-priority or round-robin grant into one output register, 1-cycle latency.
// Backpressure: a full output register that is not draining holds every field and drops every InReady.
module arb_mux_nto1 #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = 1,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] InData,
  input  logic [CHANNELS-1:0]       InValid,
  output logic [CHANNELS-1:0]       InReady,
  output logic [WIDTH-1:0]          OutData,
  output logic [SELW-1:0]           OutSel,
  output logic                      OutValid,
  input  logic                      OutReady
);

  logic [SELW-1:0]     ptr;
  logic [SELW-1:0]     start;
  logic [SELW-1:0]     cand;
  logic [SELW-1:0]     gsel;
  logic [CHANNELS-1:0] grant;
  logic                found;
  logic                free;
  logic                xfer;
  logic [WIDTH-1:0]    win_dat;
  int                  idx;

  // Search upward from the pointer, wrapping at CHANNELS-1 so non-power-of-two counts never
  // visit unused index codes.
  always_comb begin
    grant = '0;
    gsel  = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    start = (RR_MODE != 0) ? ptr : '0;
    if (!Reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(start) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        cand = idx[SELW-1:0];
        if (!found && InValid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          gsel        = cand;
        end
      end
    end
  end

  always_comb begin
    win_dat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) win_dat = InData[i*WIDTH +: WIDTH];
    end
  end

  assign free    = !OutValid || OutReady;
  assign InReady = grant & {CHANNELS{free}};
  assign xfer    = |InReady;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutData  <= '0;
      OutSel   <= '0;
      OutValid <= 1'b0;
      ptr      <= '0;
    end else begin
      if (xfer) begin
        OutData  <= win_dat;
        OutSel   <= gsel;
        OutValid <= 1'b1;
        if (RR_MODE != 0) begin
          ptr <= (gsel == SELW'(CHANNELS-1)) ? '0 : gsel + SELW'(1);
        end
      end else if (OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_nto1.sv
// Bench for arb_mux_nto1: RR 4-channel, fixed-priority 4-channel and RR 3-channel instances
// driven side by side and compared every cycle against a queue-free arithmetic reference.
module tb_arb_mux_nto1;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic [127:0] dat_a, dat_b;
  logic [95:0]  dat_c;
  logic [3:0]   vld_a, vld_b, irdy_a, irdy_b;
  logic [2:0]   vld_c, irdy_c;
  logic         ordy_a, ordy_b, ordy_c;
  logic [31:0]  od_a, od_b, od_c;
  logic [1:0]   os_a, os_b, os_c;
  logic         ov_a, ov_b, ov_c;

  arb_mux_nto1 #(.WIDTH(32), .CHANNELS(4), .RR_MODE(1)) u_rr4 (
    .Clk(Clk), .Reset(Reset), .InData(dat_a), .InValid(vld_a), .InReady(irdy_a),
    .OutData(od_a), .OutSel(os_a), .OutValid(ov_a), .OutReady(ordy_a));

  arb_mux_nto1 #(.WIDTH(32), .CHANNELS(4), .RR_MODE(0)) u_fp4 (
    .Clk(Clk), .Reset(Reset), .InData(dat_b), .InValid(vld_b), .InReady(irdy_b),
    .OutData(od_b), .OutSel(os_b), .OutValid(ov_b), .OutReady(ordy_b));

  arb_mux_nto1 #(.WIDTH(32), .CHANNELS(3), .RR_MODE(1)) u_rr3 (
    .Clk(Clk), .Reset(Reset), .InData(dat_c), .InValid(vld_c), .InReady(irdy_c),
    .OutData(od_c), .OutSel(os_c), .OutValid(ov_c), .OutReady(ordy_c));

  // Bench-side producer/consumer state, one slot per instance.
  logic [15:0] b_vld  [3];
  logic [31:0] b_dat  [3][16];
  logic        b_ordy [3];

  always_comb begin
    vld_a  = b_vld[0][3:0];
    vld_b  = b_vld[1][3:0];
    vld_c  = b_vld[2][2:0];
    ordy_a = b_ordy[0];
    ordy_b = b_ordy[1];
    ordy_c = b_ordy[2];
    dat_a  = '0;
    dat_b  = '0;
    dat_c  = '0;
    for (int i = 0; i < 4; i++) begin
      dat_a[i*32 +: 32] = b_dat[0][i];
      dat_b[i*32 +: 32] = b_dat[1][i];
    end
    for (int i = 0; i < 3; i++) dat_c[i*32 +: 32] = b_dat[2][i];
  end

  int          n_ch [3] = '{4, 4, 3};
  int          rr   [3] = '{1, 0, 1};
  logic        m_vld [3];
  logic [31:0] m_dat [3];
  int          m_sel [3];
  int          m_ptr [3];
  int          last_g [3];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int n, input int start, input logic [15:0] v);
    int c;
    for (int k = 0; k < n; k++) begin
      c = (start + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_vld[u] = 1'b0;
      m_dat[u] = '0;
      m_sel[u] = 0;
      m_ptr[u] = 0;
    end
  endtask

  // Called in the low phase: checks all outputs, then advances the model across one rising edge.
  task automatic step();
    logic [63:0] ir, od, os, ov;
    logic        free;
    int          g;
    #1;
    if (Reset) model_reset();
    for (int u = 0; u < 3; u++) begin
      case (u)
        0:       begin ir = 64'(irdy_a); od = 64'(od_a); os = 64'(os_a); ov = 64'(ov_a); end
        1:       begin ir = 64'(irdy_b); od = 64'(od_b); os = 64'(os_b); ov = 64'(ov_b); end
        default: begin ir = 64'(irdy_c); od = 64'(od_c); os = 64'(os_c); ov = 64'(ov_c); end
      endcase
      free = !m_vld[u] || b_ordy[u];
      g = (Reset || !free) ? -1 : pick(n_ch[u], (rr[u] != 0) ? m_ptr[u] : 0, b_vld[u]);
      last_g[u] = g;
      chk($sformatf("inready_u%0d", u), ir, (g >= 0) ? (64'd1 << g) : 64'd0);
      chk($sformatf("outvalid_u%0d", u), ov, 64'(m_vld[u]));
      chk($sformatf("outdata_u%0d", u), od, 64'(m_dat[u]));
      chk($sformatf("outsel_u%0d", u), os, 64'(m_sel[u]));
    end
    @(posedge Clk);
    for (int u = 0; u < 3; u++) begin
      if (Reset) begin
        m_vld[u] = 1'b0; m_dat[u] = '0; m_sel[u] = 0; m_ptr[u] = 0;
      end else if (last_g[u] >= 0) begin
        m_vld[u] = 1'b1;
        m_dat[u] = b_dat[u][last_g[u]];
        m_sel[u] = last_g[u];
        if (rr[u] != 0) m_ptr[u] = (last_g[u] + 1) % n_ch[u];
      end else if (b_ordy[u]) begin
        m_vld[u] = 1'b0;
      end
    end
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int u = 0; u < 3; u++) b_vld[u] = '0;
  endtask

  initial begin
    Reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      b_vld[u]  = 16'hFFFF;
      b_ordy[u] = 1'b1;
      for (int i = 0; i < 16; i++) b_dat[u][i] = 32'hA5A50000 + 32'(i);
    end
    model_reset();
    @(negedge Clk);

    // Reset with every channel requesting
    step();
    chk("rst_inready", 64'(irdy_a), 64'h0);
    chk("rst_outvalid", 64'(ov_a), 64'h0);
    chk("rst_outdata", 64'(od_a), 64'h0);
    chk("rst_outsel", 64'(os_a), 64'h0);
    Reset = 1'b0;
    for (int u = 0; u < 3; u++) b_vld[u] = '0;
    step();

    // Single channel, no backpressure
    b_vld[0] = 16'h0004;
    b_dat[0][2] = 32'hDEADBEEF;
    #1 chk("single_inready", 64'(irdy_a), 64'h4);
    step();
    b_vld[0] = '0;
    chk("single_outvalid", 64'(ov_a), 64'h1);
    chk("single_outdata", 64'(od_a), 64'hDEADBEEF);
    chk("single_outsel", 64'(os_a), 64'h2);
    step();

    // Round-robin fairness on u_rr4, fixed priority on u_fp4
    do_reset();
    b_vld[0] = 16'h000F;
    b_vld[1] = 16'h000A;
    for (int i = 0; i < 4; i++) begin
      b_dat[0][i] = 32'(i);
      b_dat[1][i] = $urandom;
    end
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_seq", 64'(os_a), 64'(k % 4));
      chk("fp_sel", 64'(os_b), 64'h1);
      chk("fp_ch3_never", 64'(irdy_b[3]), 64'h0);
    end
    b_vld[0] = '0;
    b_vld[1] = '0;
    step();

    // Backpressure, then simultaneous drain and fill
    b_vld[0] = 16'h0001;
    b_dat[0][0] = 32'h11111111;
    step();
    b_dat[0][0] = 32'h22222222;
    b_ordy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_data", 64'(od_a), 64'h11111111);
      chk("bp_inready", 64'(irdy_a), 64'h0);
    end
    b_ordy[0] = 1'b1;
    #1 chk("bp_drain_inready", 64'(irdy_a), 64'h1);
    step();
    b_vld[0] = '0;
    chk("bp_new_data", 64'(od_a), 64'h22222222);
    chk("bp_still_valid", 64'(ov_a), 64'h1);
    step();

    // Non-power-of-two wrap on u_rr3
    do_reset();
    b_vld[2] = 16'h0002;
    step();
    b_vld[2] = 16'h0001;
    #1 chk("np2_inready", 64'(irdy_c), 64'h1);
    step();
    chk("np2_wrap_sel", 64'(os_c), 64'h0);
    b_vld[2] = 16'h0007;
    step();
    chk("np2_after_wrap", 64'(os_c), 64'h1);
    step();
    chk("np2_next", 64'(os_c), 64'h2);
    step();
    chk("np2_wrap_again", 64'(os_c), 64'h0);
    b_vld[2] = '0;
    step();

    // Randomised traffic with occasional asynchronous reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int u = 0; u < 3; u++) begin
        for (int c = 0; c < n_ch[u]; c++) begin
          if (!b_vld[u][c] && ($urandom % 2 == 0)) begin
            b_vld[u][c] = 1'b1;
            b_dat[u][c] = $urandom;
          end
        end
        b_ordy[u] = ($urandom % 4) != 0;
      end
      Reset = ($urandom % 400) == 0;
      step();
      for (int u = 0; u < 3; u++) begin
        if (last_g[u] >= 0) b_vld[u][last_g[u]] = 1'b0;
      end
    end
    Reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/arb_mux_nto1.md
# arb_mux_nto1

Parametrised N-to-1 word multiplexer with built-in arbitration and a registered, handshaked output. It generalises the plain 2:1 select to CHANNELS producer channels. Each producer raises a valid, and the block picks a winner each cycle by fixed-priority or round-robin policy. The winner's word and channel index are captured into an output register. It sits between multiple pipeline sources (e.g. fetch redirect, BTB target, branch-resolve target) and a single consumer. It replaces ad-hoc chains of 2:1 muxes driven by hand-built select logic.

## Interface
- WIDTH, 32, data word width in bits (1..64)
- CHANNELS, 4, number of input channels (2..16)
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (channel 0 highest)
- SELW (localparam), ceil(log2(CHANNELS)), width of channel index
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- InData  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- InValid  input  CHANNELS  per-channel request
- InReady  output  CHANNELS  per-channel accept; a channel transfers when InValid[i] && InReady[i] at a rising edge
- OutData  output  WIDTH  registered selected word
- OutSel  output  SELW  registered index of the channel that supplied OutData
- OutValid  output  1  output register holds a word
- OutReady  input  1  consumer accepts OutData when OutValid && OutReady at a rising edge

## Operation
- Output register state: OutData, OutSel, OutValid. The register is free when !OutValid || OutReady (empty, or draining this cycle).
- Grant is computed combinationally from InValid and the priority pointer Ptr (SELW bits):
  - Fixed mode: lowest-index valid channel wins; Ptr is unused and stays 0.
  - RR mode: the first valid channel at or after Ptr, searching upward with wrap from CHANNELS-1 to 0, wins.
- InReady[i] = grant[i] && free. At most one InReady bit is high in any cycle. InReady is all-zero when no InValid bit is set.
- On a transfer from channel g:
  - OutData <= InData[g], OutSel <= g, OutValid <= 1.
  - RR mode only: Ptr <= g+1, wrapping to 0 after CHANNELS-1.
- If OutValid && OutReady and no channel transfers, OutValid <= 0. OutData and OutSel hold their last values.
- If OutValid && !OutReady, the output register holds every field. All InReady bits are 0 (backpressure).
- Simultaneous drain and fill in one cycle is allowed. The new word replaces the old, and OutValid stays 1.
- Ptr advances only on a transfer, never on idle or stalled cycles.
- Producers must hold InData and InValid stable until they transfer. The block does not need to tolerate a valid being withdrawn before transfer. Grant may still move to another channel if a higher-priority valid arrives.
- No combinational path from InData to any output.

## Timing
- Reset (asynchronous assert, synchronous-to-Clk deassert by the system): OutData=0, OutSel=0, OutValid=0, Ptr=0. While Reset is high, InReady=0 because grant is forced to 0.
- Latency: 1 cycle from input transfer edge to OutValid/OutData visible.
- Throughput: 1 word per cycle when OutReady is held high.
- InReady depends combinationally on OutReady and InValid within the same cycle. There is no registered ready.
- Reset asserted mid-transfer: the in-flight word is discarded, and no transfer is counted on that edge.
- CHANNELS not a power of two: grant search wraps at CHANNELS-1, never at 2^SELW-1. Ptr never holds a value >= CHANNELS.

## Test plan
- Reset check:
  - Stimulus: WIDTH=32, CHANNELS=4, RR_MODE=1. Assert Reset with all InValid=1.
  - Required response: OutValid=0, OutData=0, OutSel=0, InReady=4'b0000.
- Single channel, no backpressure:
  - Stimulus: InValid=4'b0100, InData[2]=32'hDEADBEEF, OutReady=1.
  - Required response: InReady=4'b0100. Next cycle OutValid=1, OutData=32'hDEADBEEF, OutSel=2.
- Round-robin fairness:
  - Stimulus: all four channels valid continuously with distinct data 32'h0..32'h3, OutReady=1.
  - Required response: OutSel sequence 0,1,2,3,0,1 on consecutive cycles.
- Fixed priority:
  - Stimulus: RR_MODE=0, InValid=4'b1010 held, OutReady=1.
  - Required response: channel 1 wins every cycle; channel 3 is never granted.
- Backpressure:
  - Stimulus: OutValid=1 with OutData=32'h11111111, OutReady=0 for 3 cycles, InValid=4'b0001 with InData[0]=32'h22222222. Then OutReady=1.
  - Required response: during the stall OutData stays 32'h11111111 and InReady=0. On the drain edge, channel 0 transfers at the same edge, and next cycle OutData=32'h22222222 with OutValid still 1.
- Non-power-of-two wrap:
  - Stimulus: CHANNELS=3, Ptr at 2, InValid=3'b001.
  - Required response: channel 0 is granted, then Ptr=1. Ptr never reaches 3.
